// File: rtl/modulo_hamming_top.sv
// SECDED Hamming(8,4) demonstrator: the encoder, and a top block that checks and corrects
// a received codeword and drives the LEDs and a two-digit multiplexed 7-segment display.

module modulo_codificador (
    input  logic [3:0] datos_in,
    output logic [7:0] datos_cod
);

    logic       w_p1;
    logic       w_p2;
    logic       w_p4;
    logic [6:0] w_hamming;

    assign w_p1 = datos_in[0] ^ datos_in[1] ^ datos_in[3];
    assign w_p2 = datos_in[0] ^ datos_in[2] ^ datos_in[3];
    assign w_p4 = datos_in[1] ^ datos_in[2] ^ datos_in[3];

    // Bit i holds Hamming position i+1, so parity bits land on positions 1, 2 and 4.
    assign w_hamming = {datos_in[3], datos_in[2], datos_in[1], w_p4,
                        datos_in[0], w_p2, w_p1};

    assign datos_cod = {^w_hamming, w_hamming};

endmodule

module modulo_hamming_top #(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] entrada,
    input  logic [7:0] palabra_rx,
    input  logic       select_pos,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] led_out,
    output logic       led_ded
);

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_PARITY,
        ERR_DOUBLE
    } err_e;

    localparam logic [3:0] POS_DOUBLE = 4'hE;

    logic [2:0]              w_syn;
    logic                    w_po;
    err_e                    w_err;
    logic [7:0]              w_fixed;
    logic [3:0]              w_pos;
    logic [3:0]              w_dig_left;
    logic [3:0]              w_dig_right;
    logic [3:0]              w_digit;
    logic                    w_right_sel;
    logic [REFRESH_BITS-1:0] r_refresh_cnt;

    // Each syndrome bit re-checks one parity group, including its own parity bit.
    assign w_syn[0] = palabra_rx[0] ^ palabra_rx[2] ^ palabra_rx[4] ^ palabra_rx[6];
    assign w_syn[1] = palabra_rx[1] ^ palabra_rx[2] ^ palabra_rx[5] ^ palabra_rx[6];
    assign w_syn[2] = palabra_rx[3] ^ palabra_rx[4] ^ palabra_rx[5] ^ palabra_rx[6];
    assign w_po     = ^palabra_rx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_err = ERR_NONE;
        if (w_po && (w_syn != 3'd0)) begin
            w_err = ERR_SINGLE;
        end else if (w_po) begin
            w_err = ERR_PARITY;
        end else if (w_syn != 3'd0) begin
            w_err = ERR_DOUBLE;
        end
    end

    always_comb begin
        w_fixed = palabra_rx;
        if (w_err == ERR_SINGLE) begin
            w_fixed[w_syn - 3'd1] = ~palabra_rx[w_syn - 3'd1];
        end
    end

    assign led_out = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
    assign led_ded = (w_err == ERR_DOUBLE);

    always_comb begin
        w_pos = 4'd0;
        unique case (w_err)
            ERR_NONE:   w_pos = 4'd0;
            ERR_SINGLE: w_pos = {1'b0, w_syn};
            ERR_PARITY: w_pos = 4'd8;
            ERR_DOUBLE: w_pos = POS_DOUBLE;
            default:    w_pos = 4'd0;
        endcase
    end

    assign w_dig_left  = select_pos ? {1'b0, w_syn} : entrada;
    assign w_dig_right = select_pos ? w_pos         : led_out;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + REFRESH_BITS'(1);
        end
    end

    assign w_right_sel = r_refresh_cnt[REFRESH_BITS-1];
    assign an          = w_right_sel ? 2'b01 : 2'b10;
    assign w_digit     = w_right_sel ? w_dig_right : w_dig_left;

    // Active-low segments, seg[6:0] = {g,f,e,d,c,b,a}.
    always_comb begin
        seg = 7'b1111111;
        case (w_digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_modulo_hamming_top.sv
// Self-checking bench for modulo_hamming_top: known vectors, exhaustive 0/1/2-flip sweep,
// display multiplexing and asynchronous reset behaviour.

module tb_modulo_hamming_top;

    localparam int RB = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] entrada = 4'd0;
    logic [7:0] palabra_rx = 8'd0;
    logic       select_pos = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] led_out;
    logic       led_ded;
    logic [3:0] enc_in = 4'd0;
    logic [7:0] enc_out;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] led;
        logic       ded;
        logic [6:0] seg_l;
        logic [6:0] seg_r;
    } exp_t;

    exp_t sb[$];

    // Reference model of the refresh counter: drives the expected digit phase.
    logic [RB-1:0] m_cnt;

    modulo_hamming_top #(.REFRESH_BITS(RB)) dut (
        .clk        (clk),
        .rst        (rst),
        .entrada    (entrada),
        .palabra_rx (palabra_rx),
        .select_pos (select_pos),
        .seg        (seg),
        .an         (an),
        .led_out    (led_out),
        .led_ded    (led_ded)
    );

    modulo_codificador u_enc (
        .datos_in  (enc_in),
        .datos_cod (enc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= '0;
        else     m_cnt <= m_cnt + 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] ref_enc(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, then pop and compare once outputs settle.
    task automatic send(input string tag, input logic [3:0] e, input logic [7:0] rx,
                        input logic sel, input logic [3:0] x_led, input logic x_ded,
                        input logic [6:0] x_l, input logic [6:0] x_r);
        exp_t x;
        entrada    = e;
        palabra_rx = rx;
        select_pos = sel;
        x.led = x_led; x.ded = x_ded; x.seg_l = x_l; x.seg_r = x_r;
        sb.push_back(x);
        #1;
        x = sb.pop_front();
        check({tag, "_led"}, led_out, x.led);
        check({tag, "_ded"}, led_ded, x.ded);
        check({tag, "_an"},  an, m_cnt[RB-1] ? 2'b01 : 2'b10);
        check({tag, "_seg"}, seg, m_cnt[RB-1] ? x.seg_r : x.seg_l);
    endtask

    task automatic wait_phase(input logic right);
        for (int i = 0; i < (1 << RB) + 2; i++) begin
            @(negedge clk);
            if (m_cnt[RB-1] == right) break;
        end
        check("phase_reached", m_cnt[RB-1], right);
    endtask

    task automatic send_both(input string tag, input logic [7:0] rx, input logic sel,
                             input logic [3:0] x_led, input logic x_ded,
                             input logic [6:0] x_l, input logic [6:0] x_r);
        wait_phase(1'b0);
        send({tag, "_L"}, 4'h5, rx, sel, x_led, x_ded, x_l, x_r);
        wait_phase(1'b1);
        send({tag, "_R"}, 4'h5, rx, sel, x_led, x_ded, x_l, x_r);
    endtask

    // Released at a negedge: left digit for 8 samples, right for 8, repeating.
    task automatic release_check(input string tag);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("%s_an%0d", tag, i), an, ((i / 8) % 2) ? 2'b01 : 2'b10);
        end
    endtask

    initial begin
        logic [7:0] cw;
        logic [7:0] rx;
        logic [2:0] s;

        // Reset state: left digit shown, LEDs still live.
        #1;
        send("rst0", 4'h5, 8'h2D, 1'b0, 4'h5, 1'b0, GLYPH[5], GLYPH[5]);
        check("rst0_an_fixed", an, 2'b10);
        repeat (3) @(negedge clk);
        #1;
        check("rst_held_an", an, 2'b10);

        for (int e = 0; e < 16; e++) begin
            enc_in = 4'(e);
            #1;
            check($sformatf("enc_%0d", e), enc_out, ref_enc(4'(e)));
        end
        enc_in = 4'h5;
        #1;
        check("enc_0101", enc_out, 8'h2D);

        release_check("rel");

        send_both("noerr_d",  8'h2D, 1'b0, 4'h5, 1'b0, GLYPH[5], GLYPH[5]);
        send_both("noerr_e",  8'h2D, 1'b1, 4'h5, 1'b0, GLYPH[0], GLYPH[0]);
        send_both("single_d", 8'h29, 1'b0, 4'h5, 1'b0, GLYPH[5], GLYPH[5]);
        send_both("single_e", 8'h29, 1'b1, 4'h5, 1'b0, GLYPH[3], GLYPH[3]);
        send_both("par_d",    8'hAD, 1'b0, 4'h5, 1'b0, GLYPH[5], GLYPH[5]);
        send_both("par_e",    8'hAD, 1'b1, 4'h5, 1'b0, GLYPH[0], GLYPH[8]);
        send_both("double_d", 8'h21, 1'b0, 4'h4, 1'b1, GLYPH[5], GLYPH[4]);
        send_both("double_e", 8'h21, 1'b1, 4'h4, 1'b1, GLYPH[7], GLYPH[14]);

        // Mode switch within one half-cycle: segments follow, digit phase does not move.
        wait_phase(1'b0);
        repeat (2) @(negedge clk);
        send("mode_a", 4'h5, 8'h21, 1'b0, 4'h4, 1'b1, GLYPH[5], GLYPH[4]);
        send("mode_b", 4'h5, 8'h21, 1'b1, 4'h4, 1'b1, GLYPH[7], GLYPH[14]);

        // Exhaustive 0/1/2-flip sweep in error view.
        for (int e = 0; e < 16; e++) begin
            cw = ref_enc(4'(e));
            @(negedge clk);
            send($sformatf("ex%0d_clean", e), 4'(e), cw, 1'b1, 4'(e), 1'b0,
                 GLYPH[0], GLYPH[0]);
            for (int k = 0; k < 8; k++) begin
                rx = cw ^ (8'd1 << k);
                s  = (k < 7) ? 3'(k + 1) : 3'd0;
                @(negedge clk);
                send($sformatf("ex%0d_f%0d", e, k), 4'(e), rx, 1'b1, 4'(e), 1'b0,
                     GLYPH[{1'b0, s}], (k < 7) ? GLYPH[k + 1] : GLYPH[8]);
            end
            for (int i = 0; i < 8; i++) begin
                for (int j = i + 1; j < 8; j++) begin
                    rx = cw ^ (8'd1 << i) ^ (8'd1 << j);
                    s  = ((i < 7) ? 3'(i + 1) : 3'd0) ^ ((j < 7) ? 3'(j + 1) : 3'd0);
                    @(negedge clk);
                    send($sformatf("ex%0d_f%0d_%0d", e, i, j), 4'(e), rx, 1'b1,
                         {rx[6], rx[5], rx[4], rx[2]}, 1'b1, GLYPH[{1'b0, s}], GLYPH[14]);
                end
            end
        end

        // Asynchronous reset in the middle of the right-digit phase.
        wait_phase(1'b1);
        @(negedge clk);
        #1;
        check("prerst_an", an, 2'b01);
        #1;
        rst = 1'b1;
        send("midrst", 4'h5, 8'h2D, 1'b0, 4'h5, 1'b0, GLYPH[5], GLYPH[5]);
        check("midrst_an", an, 2'b10);
        check("midrst_seg", seg, GLYPH[5]);
        repeat (2) @(negedge clk);
        release_check("rel2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
